// File: rtl/piano_pkg.sv
// Shared note/octave encodings, middle-octave half-period table and FSM states
// for the tone player.
package piano_pkg;

    localparam int HP_W  = 19;
    localparam int CNT_W = 32;

    localparam logic [3:0] NOTE_REST = 4'd0;
    localparam logic [3:0] NOTE_DO   = 4'd1;
    localparam logic [3:0] NOTE_RE   = 4'd2;
    localparam logic [3:0] NOTE_MI   = 4'd3;
    localparam logic [3:0] NOTE_FA   = 4'd4;
    localparam logic [3:0] NOTE_SOL  = 4'd5;
    localparam logic [3:0] NOTE_LA   = 4'd6;
    localparam logic [3:0] NOTE_SI   = 4'd7;

    localparam logic [1:0] OCT_LOW  = 2'd0;
    localparam logic [1:0] OCT_MID  = 2'd1;
    localparam logic [1:0] OCT_HIGH = 2'd2;

    // Index 0 is the rest slot; a zero half-period means "never toggle".
    localparam logic [HP_W-1:0] MID_HALF_PERIOD [8] = '{
        19'd0, 19'd191110, 19'd170265, 19'd151685,
        19'd143172, 19'd127551, 19'd113636, 19'd101239
    };

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_PLAY = 2'd1,
        ST_GAP  = 2'd2
    } state_t;

    // Codes 8..15 alias to rest; octave 3 plays like octave 2.
    function automatic logic [HP_W-1:0] half_period(input logic [3:0] note,
                                                    input logic [1:0] octave);
        logic [HP_W-1:0] mid;
        mid = note[3] ? '0 : MID_HALF_PERIOD[note[2:0]];
        case (octave)
            OCT_LOW: half_period = mid << 1;
            OCT_MID: half_period = mid;
            default: half_period = mid >> 1;
        endcase
    endfunction

endpackage

// File: rtl/tone_player_if.sv
// Note request handshake between a sequencer and the tone player.
interface tone_player_if;
    logic       note_valid;
    logic       note_ready;
    logic [3:0] note;
    logic [1:0] octave;
    logic [2:0] duration;

    modport master (output note_valid, note, octave, duration, input note_ready);
    modport slave  (input note_valid, note, octave, duration, output note_ready);
endinterface

// File: rtl/tone_player_divider.sv
// Square-wave generator: half-period lookup, octave scaling and toggle counter.
module tone_divider
    import piano_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    input  logic       enable,
    input  logic [3:0] note,
    input  logic [1:0] octave,
    output logic       speaker
);

    logic [HP_W-1:0] half;
    logic [HP_W-1:0] cnt_q;
    logic            spk_q;

    assign half = half_period(note, octave);

    // Dropping enable clears the phase so every note starts low.
    always_ff @(posedge clk) begin
        if (reset || !enable) begin
            cnt_q <= '0;
            spk_q <= 1'b0;
        end else if (half != '0) begin
            if (cnt_q == half - 1'b1) begin
                cnt_q <= '0;
                spk_q <= ~spk_q;
            end else begin
                cnt_q <= cnt_q + 1'b1;
            end
        end
    end

    // Gate so the output is silent in the very first cycle after PLAY ends.
    assign speaker = spk_q & enable;

endmodule

// File: rtl/tone_player.sv
// Plays one note per accepted request: tone for (duration+1) units, then a
// silent gap, with stop/reset aborting without a done pulse.
module tone_player
    import piano_pkg::*;
#(
    parameter int UNIT_CYCLES = 25_000_000,
    parameter int GAP_CYCLES  = 1_000_000
) (
    input  logic          clk,
    input  logic          reset,
    tone_player_if.slave  req,
    input  logic          stop,
    output logic          speaker,
    output logic          busy,
    output logic [3:0]    cur_note,
    output logic          done
);

    localparam logic [CNT_W-1:0] UNIT_LEN = CNT_W'(UNIT_CYCLES);
    localparam logic [CNT_W-1:0] GAP_LAST = CNT_W'(GAP_CYCLES - 1);

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [CNT_W-1:0] play_last_q, play_last_d;
    logic [3:0]       note_q;
    logic [1:0]       oct_q;
    logic             ready;
    logic             accept;
    logic             done_c;

    assign ready       = (state_q == ST_IDLE) && !stop && !reset;
    assign req.note_ready = ready;
    assign accept      = req.note_valid && ready;
    assign play_last_d = (CNT_W'(req.duration) + CNT_W'(1)) * UNIT_LEN - CNT_W'(1);

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= ST_IDLE;
            cnt_q       <= '0;
            play_last_q <= '0;
            note_q      <= '0;
            oct_q       <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            if (accept) begin
                note_q      <= req.note;
                oct_q       <= req.octave;
                play_last_q <= play_last_d;
            end
        end
    end

    // One cycle counter serves both PLAY and GAP; it restarts on each transition.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q + CNT_W'(1);
        done_c  = 1'b0;
        case (state_q)
            ST_IDLE: begin
                cnt_d = '0;
                if (accept) state_d = ST_PLAY;
            end
            ST_PLAY: begin
                if (stop) begin
                    state_d = ST_IDLE;
                    cnt_d   = '0;
                end else if (cnt_q == play_last_q) begin
                    state_d = ST_GAP;
                    cnt_d   = '0;
                end
            end
            ST_GAP: begin
                if (stop) begin
                    state_d = ST_IDLE;
                    cnt_d   = '0;
                end else if (cnt_q == GAP_LAST) begin
                    state_d = ST_IDLE;
                    cnt_d   = '0;
                    done_c  = 1'b1;
                end
            end
            default: begin
                state_d = ST_IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    assign busy     = (state_q != ST_IDLE);
    assign cur_note = busy ? note_q : 4'd0;
    assign done     = done_c && !reset;

    tone_divider u_div (
        .clk     (clk),
        .reset   (reset),
        .enable  (state_q == ST_PLAY),
        .note    (note_q),
        .octave  (oct_q),
        .speaker (speaker)
    );

endmodule

// File: tb/tb_tone_player.sv
// Directed bench for tone_player with a timeline model checked every cycle.
module tb_tone_player;

    localparam int UNIT = 400000;
    localparam int GAP  = 10;

    logic       clk = 1'b0;
    logic       reset, stop;
    logic       speaker, busy, done;
    logic [3:0] cur_note;

    tone_player_if pif();

    tone_player #(.UNIT_CYCLES(UNIT), .GAP_CYCLES(GAP)) dut (
        .clk      (clk),
        .reset    (reset),
        .req      (pif),
        .stop     (stop),
        .speaker  (speaker),
        .busy     (busy),
        .cur_note (cur_note),
        .done     (done)
    );

    initial forever #5 clk = ~clk;

    int vectors = 0, miscompares = 0, prints = 0;
    int cyc = 0, t0 = 0, done_cnt = 0, spk_hi = 0;
    int d0, s0;
    bit chk_en = 0;

    // Model: a note is a timeline of m_len tone cycles then GAP silent cycles.
    bit         m_active = 0;
    int         m_k = 0, m_hp = 0, m_len = 0;
    logic [3:0] m_note = 4'd0;
    logic       e_spk, e_busy, e_done, e_rdy;
    logic [3:0] e_cur;

    function automatic int exp_half(input int n, input int o);
        int mid;
        case (n)
            1: mid = 191110;
            2: mid = 170265;
            3: mid = 151685;
            4: mid = 143172;
            5: mid = 127551;
            6: mid = 113636;
            7: mid = 101239;
            default: mid = 0;
        endcase
        if (o == 0) return mid * 2;
        if (o == 1) return mid;
        return mid / 2;
    endfunction

    always @(posedge clk) begin
        if (reset) m_active = 0;
        else if (!m_active) begin
            if (pif.note_valid && !stop) begin
                m_active = 1;
                m_k      = 0;
                m_note   = pif.note;
                m_hp     = exp_half(int'(pif.note), int'(pif.octave));
                m_len    = (int'(pif.duration) + 1) * UNIT;
            end
        end else if (stop) m_active = 0;
        else begin
            m_k++;
            if (m_k == m_len + GAP) m_active = 0;
        end
    end

    always @(negedge clk) begin
        #1;
        if (chk_en) begin
            e_busy = m_active;
            e_cur  = m_active ? m_note : 4'd0;
            e_rdy  = !m_active && !stop && !reset;
            e_done = m_active && (m_k == m_len + GAP - 1) && !stop && !reset;
            e_spk  = m_active && (m_k < m_len) && (m_hp != 0) && ((m_k / m_hp) % 2 == 1);
            vectors++;
            if ({speaker, busy, done, pif.note_ready, cur_note} !==
                {e_spk, e_busy, e_done, e_rdy, e_cur}) begin
                miscompares++;
                if (prints < 40) begin
                    prints++;
                    $display("FAIL cycle_check t=%0t spk/busy/done/rdy/cur got %b%b%b%b/%0d expected %b%b%b%b/%0d",
                             $time, speaker, busy, done, pif.note_ready, cur_note,
                             e_spk, e_busy, e_done, e_rdy, e_cur);
                end
            end
            if (done === 1'b1) done_cnt++;
            if (speaker === 1'b1) spk_hi++;
        end
    end

    task automatic chk(input string name, input int got, input int exp);
        vectors++;
        if (got != exp) begin
            miscompares++;
            $display("FAIL %s: got %0d expected %0d", name, got, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk);
        cyc++;
    endtask

    // Returns on the negedge of the first PLAY cycle (k = 0).
    task automatic send(input logic [3:0] n, input logic [1:0] o, input logic [2:0] d);
        int w;
        w = 0;
        tick();
        pif.note_valid = 1'b1;
        pif.note       = n;
        pif.octave     = o;
        pif.duration   = d;
        #2;
        while (pif.note_ready !== 1'b1 && w < 1000) begin
            tick(); #2; w++;
        end
        chk("send_ready", int'(pif.note_ready === 1'b1), 1);
        tick();
        pif.note_valid = 1'b0;
        t0 = cyc;
    endtask

    task automatic at(input int k);
        while (cyc < t0 + k) tick();
        #2;
    endtask

    task automatic wait_done(input int limit);
        int w;
        w = 0;
        while (done !== 1'b1 && w < limit) begin
            tick(); #2; w++;
        end
        chk("done_seen", int'(done === 1'b1), 1);
    endtask

    task automatic abort();
        tick(); stop = 1'b1;
        tick(); stop = 1'b0;
        #2;
    endtask

    initial begin
        reset = 1'b1; stop = 1'b0;
        pif.note_valid = 1'b0; pif.note = 4'd0; pif.octave = 2'd0; pif.duration = 3'd0;
        tick(); tick();
        chk_en = 1; #2;
        chk("rst_busy", int'(busy), 0);
        chk("rst_spk", int'(speaker), 0);
        chk("rst_cur", int'(cur_note), 0);
        chk("rst_done", int'(done), 0);
        chk("rst_ready", int'(pif.note_ready), 0);
        tick(); reset = 1'b0; #2;
        chk("idle_ready", int'(pif.note_ready), 1);

        // la, middle octave, one unit
        send(4'd6, 2'd1, 3'd0);
        d0 = done_cnt;
        at(0);      chk("t1_spk_k0", int'(speaker), 0);
        at(113635); chk("t1_spk_113635", int'(speaker), 0);
        at(113636); chk("t1_spk_113636", int'(speaker), 1);
        at(227272); chk("t1_spk_227272", int'(speaker), 0);
        at(340908); chk("t1_spk_340908", int'(speaker), 1);
        wait_done(70000);
        chk("t1_done_k", cyc - t0, 400009);
        chk("t1_busy_last", int'(busy), 1);
        tick(); #2;
        chk("t1_busy_after", int'(busy), 0);
        chk("t1_ready_after", int'(pif.note_ready), 1);
        chk("t1_done_once", done_cnt - d0, 1);

        // octave scaling
        send(4'd6, 2'd0, 3'd0);
        at(227271); chk("lo_spk_227271", int'(speaker), 0);
        at(227272); chk("lo_spk_227272", int'(speaker), 1);
        abort();    chk("lo_abort_busy", int'(busy), 0);
        send(4'd6, 2'd2, 3'd0);
        at(56817);  chk("hi_spk_56817", int'(speaker), 0);
        at(56818);  chk("hi_spk_56818", int'(speaker), 1);
        at(113635); chk("hi_spk_113635", int'(speaker), 1);
        at(113636); chk("hi_spk_113636", int'(speaker), 0);
        abort();    chk("hi_abort_busy", int'(busy), 0);

        // stop 1000 cycles into PLAY
        send(4'd6, 2'd1, 3'd0);
        d0 = done_cnt;
        at(999);
        tick(); stop = 1'b1; #2;
        chk("st_ready_low", int'(pif.note_ready), 0);
        chk("st_busy_still", int'(busy), 1);
        tick(); stop = 1'b0; #2;
        chk("st_busy", int'(busy), 0);
        chk("st_spk", int'(speaker), 0);
        chk("st_cur", int'(cur_note), 0);
        chk("st_ready", int'(pif.note_ready), 1);
        chk("st_no_done", done_cnt - d0, 0);

        // rest for two units while a new request is held
        send(4'd0, 2'd1, 3'd1);
        d0 = done_cnt; s0 = spk_hi;
        at(5);
        pif.note_valid = 1'b1; pif.note = 4'd3; pif.octave = 2'd1; pif.duration = 3'd0;
        at(10);
        chk("hold_cur_rest", int'(cur_note), 0);
        chk("hold_ready", int'(pif.note_ready), 0);
        chk("hold_busy", int'(busy), 1);
        wait_done(900000);
        chk("rest_done_k", cyc - t0, 800009);
        chk("rest_silent", spk_hi - s0, 0);
        tick(); #2;
        chk("hold_accept_ready", int'(pif.note_ready), 1);
        chk("hold_idle_busy", int'(busy), 0);
        tick(); pif.note_valid = 1'b0; t0 = cyc; #2;
        chk("hold_cur_new", int'(cur_note), 3);
        chk("hold_busy_new", int'(busy), 1);
        chk("rest_done_once", done_cnt - d0, 1);

        // reset mid-PLAY with a pending request
        d0 = done_cnt;
        at(500);
        tick(); reset = 1'b1; pif.note_valid = 1'b1; pif.note = 4'd5; #2;
        chk("rs_ready_in_reset", int'(pif.note_ready), 0);
        tick(); #2;
        chk("rs_busy", int'(busy), 0);
        chk("rs_spk", int'(speaker), 0);
        chk("rs_cur", int'(cur_note), 0);
        chk("rs_done", int'(done), 0);
        chk("rs_ready", int'(pif.note_ready), 0);
        repeat (3) tick();
        #2;
        chk("rs_hold_busy", int'(busy), 0);
        tick(); reset = 1'b0; #2;
        chk("rs_release_ready", int'(pif.note_ready), 1);
        tick(); pif.note_valid = 1'b0; #2;
        chk("rs_accept_busy", int'(busy), 1);
        chk("rs_accept_cur", int'(cur_note), 5);
        abort();
        chk("rs_final_busy", int'(busy), 0);
        chk("rs_no_done", done_cnt - d0, 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #40_000_000;
        miscompares++;
        $display("FAIL watchdog: got timeout expected completion");
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/tone_player.md
TONE_PLAYER -- requirements
Module: tone_player

Interface
REQ-001 The module SHALL have parameter UNIT_CYCLES, default 25_000_000, the length in clk cycles of one duration unit (0.25 s at 100 MHz).
REQ-002 The module SHALL have parameter GAP_CYCLES, default 1_000_000, the silent gap in clk cycles after each note.
REQ-003 The module SHALL have one clock and a synchronous active-high reset: port clk, input, 1 bit, 100 MHz system clock.
REQ-004 The module SHALL have port reset, input, 1 bit, synchronous active-high reset.
REQ-005 The module SHALL have port note_valid, input, 1 bit, note request present.
REQ-006 The module SHALL have port note_ready, output, 1 bit, request can be accepted this cycle.
REQ-007 The module SHALL have port note, input, 4 bits: 1..7 = do..si, 0 = rest, 8..15 = rest.
REQ-008 The module SHALL have port octave, input, 2 bits: 0 = low, 1 = middle, 2 or 3 = high.
REQ-009 The module SHALL have port duration, input, 3 bits; the note lasts (duration+1) units.
REQ-010 The module SHALL have port stop, input, 1 bit, abort the current note.
REQ-011 The module SHALL have port speaker, output, 1 bit, square-wave buzzer drive.
REQ-012 The module SHALL have port busy, output, 1 bit, high when the state is not IDLE.
REQ-013 The module SHALL have port cur_note, output, 4 bits, the latched note while busy and 0 when idle.
REQ-014 The module SHALL have port done, output, 1 bit, a one-cycle pulse when a note finishes normally.

Function
REQ-015 The FSM SHALL have the states IDLE, PLAY and GAP.
REQ-016 note_ready SHALL equal (state==IDLE && !stop && !reset).
REQ-017 On note_valid && note_ready, the module SHALL latch note, octave and duration, clear all counters, and enter PLAY on the next cycle.
REQ-018 Middle-octave half-periods SHALL be, in cycles: 1:191110, 2:170265, 3:151685, 4:143172, 5:127551, 6:113636, 7:101239.
REQ-019 For low octave the half-period SHALL be doubled (left shift 1); for high octave it SHALL be halved (right shift 1, truncated).
REQ-020 In PLAY, speaker SHALL start at 0 and toggle on every cycle where the half-period counter reaches half_period-1; that counter then wraps to 0.
REQ-021 For a rest code, speaker SHALL stay 0 for the entire PLAY state; timing is unchanged.
REQ-022 PLAY SHALL last exactly (duration+1)*UNIT_CYCLES cycles, after which the FSM enters GAP and speaker is forced to 0.
REQ-023 GAP SHALL last exactly GAP_CYCLES cycles and then return to IDLE, with done high for that single transition cycle.
REQ-024 stop asserted in PLAY or GAP SHALL return the FSM to IDLE on the next edge, with speaker=0, cur_note=0 and no done pulse.
REQ-025 stop and note_valid asserted together in IDLE SHALL leave the request unaccepted.
REQ-026 note_valid asserted while busy SHALL be ignored; the requester holds it until note_ready is high.
REQ-027 The duration counter SHALL be at least 28 bits wide and the half-period counter at least 19 bits wide, with no overflow at maximum duration or low octave.

Reset
REQ-028 While reset is high, the module SHALL set state=IDLE, speaker=0, busy=0, cur_note=0, done=0, note_ready=0, and clear all counters and latches.
REQ-029 Reset asserted mid-PLAY or mid-GAP SHALL take priority over stop and the handshake, and no done pulse SHALL be produced.

Structure
REQ-030 The note code constants, octave encodings, middle-octave half-period table and FSM state encodings SHALL reside in the shared package piano_pkg.
REQ-031 The square-wave generation (half-period lookup, octave scaling, toggle counter) SHALL be in the sub-module tone_divider, with enable, note and octave inputs and a speaker output.

Verification (bench: UNIT_CYCLES=400000, GAP_CYCLES=10)
REQ-032 Apply note=6, octave=1, duration=0 -> the handshake completes in one cycle, speaker toggles at 113636, 227272 and 340908 cycles, busy stays high for 400010 cycles, and done pulses once.
REQ-033 Apply note=6 with octave=0, then again with octave=2 -> the half-period is 227272 cycles and then 56818 cycles.
REQ-034 Apply note=0, duration=1 -> speaker stays 0 for 800000 cycles with busy high, then done pulses.
REQ-035 Assert stop 1000 cycles into PLAY -> busy=0 and speaker=0 on the next cycle, note_ready returns high, and no done pulse occurs.
REQ-036 Hold note_valid during PLAY with a new note -> it is not accepted until the cycle after done, after which cur_note shows the new code.
REQ-037 Assert reset mid-PLAY while note_valid is high -> all outputs take their reset values, no acceptance occurs while reset is high, and acceptance occurs on the first cycle after reset is released.
